// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared types and constants for the MLP front-end blocks.
//   feat_t          : default feature element type (unsigned byte)
//   loader_state_e  : mlp_feature_loader FSM states
//   ERR_CNT_W       : width of the malformed-frame counter
// -----------------------------------------------------------------------------
package mlp_pkg;

    typedef logic [7:0] feat_t;

    // FILL: collecting samples into the write bank.
    // DROP: discarding the tail of an over-long frame until its s_last.
    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } loader_state_e;

    localparam int ERR_CNT_W = 16;

endpackage : mlp_pkg

// File: rtl/mlp_feature_bank.sv
// -----------------------------------------------------------------------------
// mlp_feature_bank
// Two D1-entry vector banks with a single element write port and a whole-bank
// read port. Storage has no reset; contents are only meaningful once the
// loader has marked a bank full.
// Ports:
//   clk_i      : clock
//   wr_sel_i   : bank being written
//   wr_idx_i   : element index within the write bank
//   wr_data_i  : element value
//   wr_en_i    : write strobe
//   rd_sel_i   : bank presented on rd_data_o
//   rd_data_o  : full vector of the selected bank
// -----------------------------------------------------------------------------
module mlp_feature_bank
    import mlp_pkg::*;
#(
    parameter type T     = feat_t,
    parameter int  D1    = 8,
    localparam int IDX_W = $clog2(D1)
) (
    input  logic             clk_i,
    input  logic             wr_sel_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  T                 wr_data_i,
    input  logic             wr_en_i,
    input  logic             rd_sel_i,
    output T                 rd_data_o [D1]
);

    T mem_q [2][D1];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_sel_i][wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_sel_i];

endmodule : mlp_feature_bank

// File: rtl/mlp_feature_loader.sv
// -----------------------------------------------------------------------------
// mlp_feature_loader
// Packs a stream of sensor samples into D1-element feature vectors for the
// dense layer, double-buffered so one vector can be filled while the other
// waits to be consumed. Malformed frames (s_last early or missing) are
// discarded and counted.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and m_valid/m_data only change after a
// transfer or when a new vector completes.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : sample stream in
//   m_valid/m_ready/m_data   : feature vector out (registered, no s_* path)
//   frame_err                : one-cycle pulse per malformed frame
//   err_cnt                  : saturating malformed-frame count
//   dbg_state                : current FSM state, for observation
// -----------------------------------------------------------------------------
module mlp_feature_loader
    import mlp_pkg::*;
#(
    parameter type T  = feat_t,
    parameter int  D1 = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  T                     s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output T                     m_data [D1],
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output loader_state_e        dbg_state
);

    localparam int               IDX_W    = $clog2(D1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D1 - 1);

    loader_state_e        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wsel_q, wsel_d;
    logic                 rsel_q, rsel_d;
    logic [1:0]           full_cnt_q, full_cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    // Holds s_ready low until the first edge after reset release.
    logic                 live_q;

    logic accept;
    logic drain;
    logic complete;
    logic bank_we;

    assign s_ready   = live_q && ((state_q == DROP) || (full_cnt_q != 2'd2));
    assign accept    = s_valid && s_ready;
    assign m_valid   = (full_cnt_q != 2'd0);
    assign drain     = m_valid && m_ready;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_cnt_q  <= 2'd0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            full_cnt_q  <= full_cnt_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            live_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wsel_d      = wsel_q;
        frame_err_d = 1'b0;
        complete    = 1'b0;
        bank_we     = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    // Writing a sample of a frame that later turns out bad is
                    // harmless: the write bank is never a full one.
                    bank_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s_last) begin
                            complete = 1'b1;
                            wsel_d   = ~wsel_q;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = DROP;
                        end
                    end else if (s_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        rsel_d     = drain ? ~rsel_q : rsel_q;
        full_cnt_d = full_cnt_q;
        // A completion and a drain in the same cycle cancel out.
        case ({complete, drain})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase
        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    mlp_feature_bank #(
        .T  (T),
        .D1 (D1)
    ) u_bank (
        .clk_i     (clk),
        .wr_sel_i  (wsel_q),
        .wr_idx_i  (idx_q),
        .wr_data_i (s_data),
        .wr_en_i   (bank_we),
        .rd_sel_i  (rsel_q),
        .rd_data_o (m_data)
    );

endmodule : mlp_feature_loader

// File: doc/mlp_feature_loader.md
MLP_FEATURE_LOADER -- requirements
Module: mlp_feature_loader

Interface
REQ-001 SHALL have parameter T, default logic [7:0]; the feature element type, matching the dense layer's T.
REQ-002 SHALL have parameter D1, default 8; the number of features per vector (≥2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_valid, input, 1 bit: sensor sample valid.
REQ-006 SHALL have port s_ready, output, 1 bit: the loader accepts a sample.
REQ-007 SHALL have port s_data, input, T: the sensor sample.
REQ-008 SHALL have port s_last, input, 1 bit: marks the final sample of a frame.
REQ-009 SHALL have port m_valid, output, 1 bit: a feature vector is available.
REQ-010 SHALL have port m_ready, input, 1 bit: the downstream dense layer consumes the vector.
REQ-011 SHALL have port m_data, output, T [D1]: the feature vector, routed to the dense layer din.
REQ-012 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a malformed frame.
REQ-013 SHALL have port err_cnt, output, 16 bits: the saturating count of malformed frames.

Function
REQ-014 SHALL hold two vector banks, a write-bank select wsel, a read-bank select rsel, and a full-bank count full_cnt in the range 0..2.
REQ-015 SHALL accept a sample only when s_valid && s_ready in the same cycle.
REQ-016 SHALL run an FSM with states FILL and DROP; reset state is FILL.
REQ-017 SHALL, in FILL, drive s_ready = (full_cnt < 2).
REQ-018 SHALL, in DROP, drive s_ready = 1.
REQ-019 SHALL, on each accept in FILL, write s_data to bank[wsel][idx], where idx is a counter of width $clog2(D1).
REQ-020 SHALL, on an accept in FILL with idx == D1-1 and s_last == 1 (good frame): mark the bank full, toggle wsel, clear idx, and increment full_cnt.
REQ-021 SHALL, on an accept in FILL with idx < D1-1 and s_last == 1 (short frame): discard the partial vector, clear idx, pulse frame_err, and leave wsel unchanged.
REQ-022 SHALL, on an accept in FILL with idx == D1-1 and s_last == 0 (long frame): discard the vector, clear idx, pulse frame_err, and go to DROP.
REQ-023 SHALL, in DROP, discard all accepted samples and return to FILL on the cycle after an accepted s_last; no further frame_err is raised.
REQ-024 SHALL drive m_valid = (full_cnt > 0) and m_data = bank[rsel], both registered with no combinational path from the s_* inputs.
REQ-025 SHALL assert m_valid in the cycle after the completing sample is accepted (latency 1).
REQ-026 SHALL, on m_valid && m_ready, toggle rsel and decrement full_cnt.
REQ-027 SHALL hold m_data stable while m_valid && !m_ready.
REQ-028 SHALL leave full_cnt unchanged when a bank completion and a drain occur in the same cycle; both selects still toggle.
REQ-029 SHALL never overwrite a full bank; when full_cnt == 2, s_ready = 0 in FILL.
REQ-030 SHALL increment err_cnt on each frame_err pulse, saturating at 16'hFFFF.

Reset
REQ-031 SHALL, while rst_n = 0, force: FILL state, idx = 0, wsel = 0, rsel = 0, full_cnt = 0, m_valid = 0, s_ready = 0, frame_err = 0, err_cnt = 0.
REQ-032 SHALL NOT reset bank contents; m_data is don't-care while m_valid = 0.
REQ-033 SHALL drive s_ready = 1 from the first clock edge after rst_n deasserts.
REQ-034 SHALL, on reset mid-frame or mid-handshake, discard all partial and full vectors.

Structure
REQ-035 SHALL place the default feature type feat_t, the FSM enum loader_state_e, and the error-counter width ERR_CNT_W = 16 in the shared package mlp_pkg.
REQ-036 SHALL implement bank storage as one sub-module, mlp_feature_bank: two D1-entry banks with write port (sel, idx, data, we) and read port (sel); no reset on storage.

Verification
REQ-037 SHALL cover back-to-back frames: with D1 = 4, send {1,2,3,4 last}, then {5,6,7,8 last}, with m_ready = 1 → m_data = {1,2,3,4} one cycle after the 4th accept, then {5,6,7,8}; frame_err never asserted.
REQ-038 SHALL cover backpressure: with m_ready = 0, send three good frames → s_ready drops after the 2nd frame completes; raising m_ready yields vectors in order with no loss.
REQ-039 SHALL cover a short frame: send {9,9 last}, then {1,2,3,4 last} → one frame_err pulse, err_cnt = 1, only {1,2,3,4} is output.
REQ-040 SHALL cover a long frame: send 4 samples with no last, then 2 more with last on the 6th, then a good frame → frame_err pulses on the 4th accept, the next good frame is output intact.
REQ-041 SHALL cover simultaneous completion and drain: full_cnt = 1 with m_ready = 1 in the same cycle a frame completes → full_cnt stays 1, m_valid stays high, the new vector follows.
REQ-042 SHALL cover reset mid-operation: assert rst_n = 0 mid-frame with one bank full → m_valid = 0, err_cnt = 0, s_ready = 1 after release; the first following frame outputs correctly.
